// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer arbiter.
//   buzz_state_e   : sequencing states IDLE / ON / OFF
//   DEF_TONE_DIVk  : default tone period-1 values (50 MHz clock)
//   cnt_w / max_u  : width helpers for counters sized from their maximum value
package buzzer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } buzz_state_e;

  localparam int unsigned DEF_TONE_DIV0 = 190839;  // 262 Hz
  localparam int unsigned DEF_TONE_DIV1 = 151685;  // 330 Hz
  localparam int unsigned DEF_TONE_DIV2 = 127551;  // 392 Hz

  // Bits needed to hold values 0..max_val (at least 1).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/buzz_tone_gen.sv
// Square-wave tone generator.
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   clr  : synchronous restart of the period counter
//   div  : tone period-1 in clk cycles
//   tone : high while freq_cnt >= div>>1 (roughly 50% duty)
module buzz_tone_gen #(
  parameter int unsigned W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] div,
  output logic         tone
);

  logic [W-1:0] freq_cnt;

  // >= rather than == so a divider change mid-count still wraps promptly
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      freq_cnt <= '0;
    end else if (freq_cnt >= div) begin
      freq_cnt <= '0;
    end else begin
      freq_cnt <= freq_cnt + W'(1);
    end
  end

  assign tone = (freq_cnt >= (div >> 1));

endmodule

// File: rtl/buzzer_arbiter.sv
// Fixed-priority buzzer arbiter: shares one beep pin between N_REQ alarm
// sources. The granted source plays BURSTS beeps of ON_TICKS tone followed
// by OFF_TICKS silence, then the block re-arbitrates (highest index wins).
//   clk   : system clock
//   rst   : synchronous reset, active-high
//   req   : level requests, already synchronous to clk
//   mute  : forces beep low, sequencing unaffected
//   grant : one-hot current owner, zero when idle
//   busy  : high in ON/OFF
//   beep  : registered buzzer drive
// Build option: define BUZZ_PREEMPT_EN to let a higher-index request
// preempt an active burst set (restarting it under the new tone).
module buzzer_arbiter
  import buzzer_pkg::*;
#(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned TONE_DIV0 = DEF_TONE_DIV0,
  parameter int unsigned TONE_DIV1 = DEF_TONE_DIV1,
  parameter int unsigned TONE_DIV2 = DEF_TONE_DIV2,
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned ON_TICKS  = 200,
  parameter int unsigned OFF_TICKS = 100,
  parameter int unsigned BURSTS    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             mute,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             beep
);

  localparam int unsigned IDX_W   = cnt_w(N_REQ - 1);
  localparam int unsigned FREQ_W  = cnt_w(max_u(TONE_DIV0, max_u(TONE_DIV1, TONE_DIV2)));
  localparam int unsigned PRE_W   = cnt_w(TICK_DIV - 1);
  localparam int unsigned TICK_W  = cnt_w(max_u(ON_TICKS, OFF_TICKS) - 1);
  localparam int unsigned BURST_W = cnt_w(BURSTS);

  localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0]  ON_LAST    = TICK_W'(ON_TICKS - 1);
  localparam logic [TICK_W-1:0]  OFF_LAST   = TICK_W'(OFF_TICKS - 1);
  localparam logic [BURST_W-1:0] BURST_INIT = BURST_W'(BURSTS);

  buzz_state_e        state;
  logic [IDX_W-1:0]   grant_idx;
  logic [PRE_W-1:0]   pre_cnt;
  logic [TICK_W-1:0]  tick_cnt;
  logic [BURST_W-1:0] burst_cnt;

  logic [IDX_W-1:0]   req_idx;
  logic [N_REQ-1:0]   req_onehot;
  logic               req_any;
  logic               tick_end;
  logic               on_done;
  logic               off_done;
  logic               last_burst;
  logic               preempt;
  logic               enter_on;
  logic [FREQ_W-1:0]  div_sel;
  logic               tone;

  always_comb begin
    req_any = |req;
    req_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req[i]) req_idx = IDX_W'(i);
    end
    req_onehot          = '0;
    req_onehot[req_idx] = 1'b1;

    tick_end   = (pre_cnt == PRE_LAST);
    on_done    = (state == ST_ON)  && tick_end && (tick_cnt == ON_LAST);
    off_done   = (state == ST_OFF) && tick_end && (tick_cnt == OFF_LAST);
    last_burst = (burst_cnt == BURST_W'(1));

`ifdef BUZZ_PREEMPT_EN
    preempt = (state != ST_IDLE) && req_any && (req_idx > grant_idx);
`else
    preempt = 1'b0;
`endif

    enter_on = ((state == ST_IDLE) && req_any) || (off_done && !last_burst) || preempt;

    if (grant_idx == IDX_W'(0)) begin
      div_sel = FREQ_W'(TONE_DIV0);
    end else if (grant_idx == IDX_W'(1)) begin
      div_sel = FREQ_W'(TONE_DIV1);
    end else begin
      div_sel = FREQ_W'(TONE_DIV2);
    end
  end

  buzz_tone_gen #(
    .W (FREQ_W)
  ) u_tone (
    .clk  (clk),
    .rst  (rst),
    .clr  (enter_on),
    .div  (div_sel),
    .tone (tone)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant     <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
      beep      <= 1'b0;
      pre_cnt   <= '0;
      tick_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      // The beep register is cleared on the last ON cycle and on a preempt
      // so OFF is silent from its first cycle and a new grant starts low.
      beep <= (state == ST_ON) && !on_done && !preempt && !mute && tone;

      if (enter_on) begin
        state    <= ST_ON;
        busy     <= 1'b1;
        pre_cnt  <= '0;
        tick_cnt <= '0;
        if ((state == ST_IDLE) || preempt) begin
          grant     <= req_onehot;
          grant_idx <= req_idx;
          burst_cnt <= BURST_INIT;
        end else begin
          burst_cnt <= burst_cnt - BURST_W'(1);
        end
      end else if (on_done) begin
        state    <= ST_OFF;
        pre_cnt  <= '0;
        tick_cnt <= '0;
      end else if (off_done) begin
        state     <= ST_IDLE;
        busy      <= 1'b0;
        grant     <= '0;
        grant_idx <= '0;
        burst_cnt <= '0;
        pre_cnt   <= '0;
        tick_cnt  <= '0;
      end else if (state != ST_IDLE) begin
        if (tick_end) begin
          pre_cnt  <= '0;
          tick_cnt <= tick_cnt + TICK_W'(1);
        end else begin
          pre_cnt <= pre_cnt + PRE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed self-checking bench for buzzer_arbiter with a small timing
// configuration (TICK_DIV=4, ON_TICKS=3, OFF_TICKS=2, BURSTS=2, tone
// dividers 7/9/11): one burst set is 40 cycles (12 ON + 8 OFF, twice).
module tb_buzzer_arbiter;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       mute = 1'b0;
  logic [2:0] req  = '0;
  logic [2:0] grant;
  logic       busy;
  logic       beep;

  int checks = 0;
  int errors = 0;
  string phase = "reset";

  // expected {grant, busy, beep} for the cycle following each driven edge
  logic [4:0] sb[$];

  buzzer_arbiter #(
    .N_REQ     (3),
    .TONE_DIV0 (7),
    .TONE_DIV1 (9),
    .TONE_DIV2 (11),
    .TICK_DIV  (4),
    .ON_TICKS  (3),
    .OFF_TICKS (2),
    .BURSTS    (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .mute  (mute),
    .grant (grant),
    .busy  (busy),
    .beep  (beep)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (phase %s)", phase);
    $fatal(1, "watchdog expired");
  end

  // Expected outputs at cycle t (0..39) of a granted burst set. Beep k of
  // an ON interval reflects freq_cnt=k-1 (one-cycle register latency).
  function automatic logic [4:0] set_exp(input logic [2:0] g, input int unsigned div,
                                         input bit mute2, input int unsigned t);
    int unsigned b;
    int unsigned r;
    logic bp;
    b  = t / 20;
    r  = t % 20;
    bp = 1'b0;
    if ((r < 12) && (r >= 1) && (((r - 1) % (div + 1)) >= (div / 2)) && !(mute2 && (b == 1)))
      bp = 1'b1;
    return {g, 1'b1, bp};
  endfunction

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s [%s] t=%0t got %b expected %b", tag, phase, $time, got, exp);
    end
  endtask

  task automatic cycle(input logic [4:0] e);
    logic [4:0] x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("grant", grant, x[4:2]);
    check("busy", {2'b00, busy}, {2'b00, x[1]});
    check("beep", {2'b00, beep}, {2'b00, x[0]});
  endtask

  task automatic play_range(input logic [2:0] g, input int unsigned div, input bit mute2,
                            input int unsigned from, input int unsigned to);
    for (int unsigned t = from; t < to; t++) begin
      if (mute2) mute = (t >= 20) && (t < 32);
      cycle(set_exp(g, div, mute2, t));
    end
    mute = 1'b0;
  endtask

  initial begin
    // reset state
    cycle(5'b0);
    cycle(5'b0);
    rst = 1'b0;
    cycle(5'b0);

    // 1: single requester, then back-to-back re-grant
    phase = "single";
    req = 3'b001;
    play_range(3'b001, 7, 1'b0, 0, 40);
    cycle(5'b0);
    play_range(3'b001, 7, 1'b0, 0, 40);
    req = 3'b000;
    cycle(5'b0);
    cycle(5'b0);

    // 2: simultaneous requests, highest wins, lower served afterwards
    phase = "priority";
    req = 3'b101;
    play_range(3'b100, 11, 1'b0, 0, 40);
    req = 3'b001;
    cycle(5'b0);
    play_range(3'b001, 7, 1'b0, 0, 40);
    req = 3'b000;
    cycle(5'b0);
    cycle(5'b0);

    // 3: one-cycle request pulse still plays the full set
    phase = "pulse";
    req = 3'b010;
    play_range(3'b010, 9, 1'b0, 0, 1);
    req = 3'b000;
    play_range(3'b010, 9, 1'b0, 1, 40);
    cycle(5'b0);
    cycle(5'b0);

    // 4: mute during the second ON interval
    phase = "mute";
    req = 3'b001;
    play_range(3'b001, 7, 1'b1, 0, 40);
    req = 3'b000;
    cycle(5'b0);

    // 5: reset in the middle of ON, request held
    phase = "midreset";
    req = 3'b010;
    play_range(3'b010, 9, 1'b0, 0, 6);
    rst = 1'b1;
    cycle(5'b0);
    rst = 1'b0;
    play_range(3'b010, 9, 1'b0, 0, 40);
    req = 3'b000;
    cycle(5'b0);
    cycle(5'b0);

    // 6: higher request arrives during OFF
    phase = "preempt";
    req = 3'b001;
    play_range(3'b001, 7, 1'b0, 0, 14);
    req = 3'b101;
`ifdef BUZZ_PREEMPT_EN
    play_range(3'b100, 11, 1'b0, 0, 40);
`else
    play_range(3'b001, 7, 1'b0, 14, 40);
    cycle(5'b0);
    play_range(3'b100, 11, 1'b0, 0, 40);
`endif
    req = 3'b000;
    cycle(5'b0);
    cycle(5'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
